// File: rtl/core_pkg.sv
// Shared constants and types for the RV32I core pipeline.
// Control bundle carried between Decode and Execute, plus its bubble encoding.
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned ALUCTRL_W = 3;

  // Writeback result source select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic [ALUCTRL_W-1:0] alu_control;
  } ctrl_de_t;

  localparam ctrl_de_t CTRL_NOP = '0;

  localparam int unsigned CTRL_W = $bits(ctrl_de_t);

  // True when the control bundle has an architecturally visible side effect.
  function automatic logic ctrl_has_effect(input ctrl_de_t c);
    return c.reg_write | c.mem_write | c.jump | c.branch;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async active-low clear, synchronous clear and enable.
// Synchronous clear has priority over enable so a flush wins over a stall.
module pipe_field_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] field_d;
  logic [Width-1:0] field_q;

  always_comb begin
    field_d = field_q;
    if (clr_i) begin
      field_d = '0;
    end else if (en_i) begin
      field_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      field_q <= '0;
    end else begin
      field_q <= field_d;
    end
  end

  assign q_o = field_q;

endmodule

// File: rtl/pipe_reg_de.sv
// Decode-to-Execute pipeline register with flush, stall and per-entry valid bit.
// Optional BUBBLE_CNT_EN adds a saturating count of bubbles entering Execute.
module pipe_reg_de #(
  parameter int unsigned XLEN      = core_pkg::XLEN,
  parameter int unsigned REG_AW    = core_pkg::REG_AW,
  parameter int unsigned ALUCTRL_W = core_pkg::ALUCTRL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Flush_E,
  input  logic                 Stall_E,
  input  logic                 Valid_D,
  input  logic [XLEN-1:0]      RD1_D,
  input  logic [XLEN-1:0]      RD2_D,
  input  logic [REG_AW-1:0]    Rs1_D,
  input  logic [REG_AW-1:0]    Rs2_D,
  input  logic [REG_AW-1:0]    Rd_D,
  input  logic [XLEN-1:0]      ImmExt_D,
  input  logic [XLEN-1:0]      PC_D,
  input  logic [XLEN-1:0]      PCPlus4_D,
  input  logic                 RegWrite_D,
  input  logic [1:0]           ResultSrc_D,
  input  logic                 MemWrite_D,
  input  logic                 Jump_D,
  input  logic                 Branch_D,
  input  logic                 ALUSrc_D,
  input  logic [ALUCTRL_W-1:0] ALUControl_D,
  output logic                 Valid_E,
  output logic [XLEN-1:0]      RD1_E,
  output logic [XLEN-1:0]      RD2_E,
  output logic [REG_AW-1:0]    Rs1_E,
  output logic [REG_AW-1:0]    Rs2_E,
  output logic [REG_AW-1:0]    Rd_E,
  output logic [XLEN-1:0]      ImmExt_E,
  output logic [XLEN-1:0]      PC_E,
  output logic [XLEN-1:0]      PCPlus4_E,
  output logic                 RegWrite_E,
  output logic [1:0]           ResultSrc_E,
  output logic                 MemWrite_E,
  output logic                 Jump_E,
  output logic                 Branch_E,
  output logic                 ALUSrc_E,
  output logic [ALUCTRL_W-1:0] ALUControl_E
`ifdef BUBBLE_CNT_EN
  ,
  output logic [31:0]          BubbleCount_E
`endif
);

  import core_pkg::*;

  localparam int unsigned DataW = 5 * XLEN;
  localparam int unsigned AddrW = 3 * REG_AW;

  logic     clr;
  logic     en;
  ctrl_de_t ctrl_d;
  ctrl_de_t ctrl_q;

  logic [DataW-1:0] data_d;
  logic [DataW-1:0] data_q;
  logic [AddrW-1:0] addr_d;
  logic [AddrW-1:0] addr_q;
  logic             valid_q;

  // A load of an invalid Decode entry is squashed exactly like a flush.
  assign clr = Flush_E | (~Stall_E & ~Valid_D);
  assign en  = ~Stall_E;

  assign data_d = {RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D};
  assign addr_d = {Rs1_D, Rs2_D, Rd_D};

  always_comb begin
    ctrl_d             = CTRL_NOP;
    ctrl_d.reg_write   = RegWrite_D;
    ctrl_d.result_src  = ResultSrc_D;
    ctrl_d.mem_write   = MemWrite_D;
    ctrl_d.jump        = Jump_D;
    ctrl_d.branch      = Branch_D;
    ctrl_d.alu_src     = ALUSrc_D;
    ctrl_d.alu_control = ALUControl_D;
  end

  pipe_field_reg #(
    .Width (DataW)
  ) u_data_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .en_i   (en),
    .d_i    (data_d),
    .q_o    (data_q)
  );

  pipe_field_reg #(
    .Width (AddrW)
  ) u_addr_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .en_i   (en),
    .d_i    (addr_d),
    .q_o    (addr_q)
  );

  pipe_field_reg #(
    .Width (CTRL_W)
  ) u_ctrl_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .en_i   (en),
    .d_i    (ctrl_d),
    .q_o    (ctrl_q)
  );

  pipe_field_reg #(
    .Width (1)
  ) u_valid_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .en_i   (en),
    .d_i    (Valid_D),
    .q_o    (valid_q)
  );

  assign {RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E} = data_q;
  assign {Rs1_E, Rs2_E, Rd_E}                      = addr_q;

  assign Valid_E      = valid_q;
  assign RegWrite_E   = ctrl_q.reg_write;
  assign ResultSrc_E  = ctrl_q.result_src;
  assign MemWrite_E   = ctrl_q.mem_write;
  assign Jump_E       = ctrl_q.jump;
  assign Branch_E     = ctrl_q.branch;
  assign ALUSrc_E     = ctrl_q.alu_src;
  assign ALUControl_E = ctrl_q.alu_control;

`ifdef BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_d;
  logic [31:0] bubble_cnt_q;

  // Every clearing edge leaves Valid_E low; stalls never clear.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (clr && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign BubbleCount_E = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_de.sv
// Directed self-checking bench for pipe_reg_de (default build and BUBBLE_CNT_EN).
module tb_pipe_reg_de;

  logic        clk;
  logic        rst_n;
  logic        Flush_E, Stall_E, Valid_D;
  logic [31:0] RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D;
  logic [4:0]  Rs1_D, Rs2_D, Rd_D;
  logic        RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrc_D;
  logic [1:0]  ResultSrc_D;
  logic [2:0]  ALUControl_D;

  logic        Valid_E;
  logic [31:0] RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E;
  logic [4:0]  Rs1_E, Rs2_E, Rd_E;
  logic        RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E;
  logic [1:0]  ResultSrc_E;
  logic [2:0]  ALUControl_E;
`ifdef BUBBLE_CNT_EN
  logic [31:0] BubbleCount_E;
`endif

  int n_cmp;
  int n_err;

  pipe_reg_de dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Flush_E      (Flush_E),
    .Stall_E      (Stall_E),
    .Valid_D      (Valid_D),
    .RD1_D        (RD1_D),
    .RD2_D        (RD2_D),
    .Rs1_D        (Rs1_D),
    .Rs2_D        (Rs2_D),
    .Rd_D         (Rd_D),
    .ImmExt_D     (ImmExt_D),
    .PC_D         (PC_D),
    .PCPlus4_D    (PCPlus4_D),
    .RegWrite_D   (RegWrite_D),
    .ResultSrc_D  (ResultSrc_D),
    .MemWrite_D   (MemWrite_D),
    .Jump_D       (Jump_D),
    .Branch_D     (Branch_D),
    .ALUSrc_D     (ALUSrc_D),
    .ALUControl_D (ALUControl_D),
    .Valid_E      (Valid_E),
    .RD1_E        (RD1_E),
    .RD2_E        (RD2_E),
    .Rs1_E        (Rs1_E),
    .Rs2_E        (Rs2_E),
    .Rd_E         (Rd_E),
    .ImmExt_E     (ImmExt_E),
    .PC_E         (PC_E),
    .PCPlus4_E    (PCPlus4_E),
    .RegWrite_E   (RegWrite_E),
    .ResultSrc_E  (ResultSrc_E),
    .MemWrite_E   (MemWrite_E),
    .Jump_E       (Jump_E),
    .Branch_E     (Branch_E),
    .ALUSrc_E     (ALUSrc_E),
    .ALUControl_E (ALUControl_E)
`ifdef BUBBLE_CNT_EN
    ,
    .BubbleCount_E (BubbleCount_E)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_busy();
    Valid_D = 1'b1;  RD1_D = 32'hAAAA_0001; RD2_D = 32'hBBBB_0002;
    Rs1_D = 5'd11;   Rs2_D = 5'd12;         Rd_D = 5'd13;
    ImmExt_D = 32'h0000_0FF0; PC_D = 32'h0000_0200; PCPlus4_D = 32'h0000_0204;
    RegWrite_D = 1'b1; ResultSrc_D = 2'b10; MemWrite_D = 1'b1; Jump_D = 1'b1;
    Branch_D = 1'b1;   ALUSrc_D = 1'b1;     ALUControl_D = 3'b111;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},  {63'd0, Valid_E}, 64'd0);
    check({tag, ".rd1"},    {32'd0, RD1_E}, 64'd0);
    check({tag, ".rd2"},    {32'd0, RD2_E}, 64'd0);
    check({tag, ".addr"},   {49'd0, Rs1_E, Rs2_E, Rd_E}, 64'd0);
    check({tag, ".imm_pc"}, {ImmExt_E, PC_E ^ PCPlus4_E}, 64'd0);
    check({tag, ".pc"},     {32'd0, PC_E}, 64'd0);
    check({tag, ".ctrl"},
          {54'd0, RegWrite_E, ResultSrc_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E, ALUControl_E},
          64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Flush_E = 1'b0;
    Stall_E = 1'b0;
    drive_busy();

    // Reset with busy inputs
    rst_n = 1'b0;
    #2;
    check_zero("reset_async");
    tick();
    check_zero("reset_edge");
    #2 rst_n = 1'b1;

    // First load after release
    RD1_D = 32'h1234_5678; Rd_D = 5'd5; Valid_D = 1'b1;
    tick();
    check("load1.rd1",   {32'd0, RD1_E}, 64'h1234_5678);
    check("load1.rd",    {59'd0, Rd_E}, 64'd5);
    check("load1.valid", {63'd0, Valid_E}, 64'd1);

    // Full control/data load
    RegWrite_D = 1'b1; ALUControl_D = 3'b010; ImmExt_D = 32'hFFFF_FFF0;
    PC_D = 32'h100; PCPlus4_D = 32'h104; MemWrite_D = 1'b0; ResultSrc_D = 2'b01;
    tick();
    check("load2.aluctl", {61'd0, ALUControl_E}, 64'd2);
    check("load2.imm",    {32'd0, ImmExt_E}, 64'hFFFF_FFF0);
    check("load2.pc",     {32'd0, PC_E}, 64'h100);
    check("load2.pc4",    {32'd0, PCPlus4_E}, 64'h104);
    check("load2.regwr",  {63'd0, RegWrite_E}, 64'd1);
    check("load2.ressrc", {62'd0, ResultSrc_E}, 64'd1);
    check("load2.memwr",  {63'd0, MemWrite_E}, 64'd0);

    // Flush of a valid entry
    Rd_D = 5'd7; Rs1_D = 5'd3; RegWrite_D = 1'b1; Flush_E = 1'b1;
    tick();
    check_zero("flush");
    Flush_E = 1'b0;

    // Stall holds, release loads
    Rd_D = 5'd3;
    tick();
    check("stall.pre", {59'd0, Rd_E}, 64'd3);
    Stall_E = 1'b1; Rd_D = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.hold", {59'd0, Rd_E}, 64'd3);
      check("stall.valid", {63'd0, Valid_E}, 64'd1);
    end
    Stall_E = 1'b0;
    tick();
    check("stall.release", {59'd0, Rd_E}, 64'd9);

    // Flush and stall together: flush wins
    Flush_E = 1'b1; Stall_E = 1'b1;
    tick();
    check("flush_stall.valid", {63'd0, Valid_E}, 64'd0);
    check("flush_stall.rd",    {59'd0, Rd_E}, 64'd0);
    Flush_E = 1'b0; Stall_E = 1'b0;

    // Invalid Decode entry on a load acts as a bubble
    Valid_D = 1'b0; MemWrite_D = 1'b1; Rd_D = 5'd17;
    tick();
    check("invalid.memwr", {63'd0, MemWrite_E}, 64'd0);
    check("invalid.valid", {63'd0, Valid_E}, 64'd0);
    check("invalid.rd",    {59'd0, Rd_E}, 64'd0);

    // Async reset asserted mid-stall
    drive_busy();
    tick();
    check("prereset.rd", {59'd0, Rd_E}, 64'd13);
    Stall_E = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_zero("reset_midstall");
    #2 rst_n = 1'b1;
    Stall_E = 1'b0;

    // Bubble count scenario: 2 flushes, 1 stall, 1 invalid load
    drive_busy();
    tick();
    check("bc.load.valid", {63'd0, Valid_E}, 64'd1);
    Flush_E = 1'b1;
    tick();
    tick();
    Flush_E = 1'b0; Stall_E = 1'b1;
    tick();
    check("bc.stall.valid", {63'd0, Valid_E}, 64'd0);
    Stall_E = 1'b0; Valid_D = 1'b0;
    tick();
    check("bc.inv.valid", {63'd0, Valid_E}, 64'd0);
`ifdef BUBBLE_CNT_EN
    check("bubble_count", {32'd0, BubbleCount_E}, 64'd3);
    Valid_D = 1'b1;
    tick();
    check("bubble_count.hold", {32'd0, BubbleCount_E}, 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg_de.md
Name: pipe_reg_de

Overview:
Decode-to-Execute pipeline register of the 5-stage RV32I core. Captures the Decode-stage operands, register addresses, immediate, PC values and control bundle each cycle, and presents them to Execute. Execute consumers include the SrcA/SrcB forwarding muxes (RD1_E/RD2_E), the hazard unit (Rs1_E/Rs2_E/Rd_E) and the ALU. Supports flush (bubble insertion for load-use and taken branch/jump), stall (hold), and a per-entry valid bit.

Parameters:
XLEN, 32, datapath width of operands, immediate and PC
REG_AW, 5, register-file address width
ALUCTRL_W, 3, ALUControl width

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
Flush_E  input  1  from hazard unit; squash entry next edge
Stall_E  input  1  hold current entry
Valid_D  input  1  Decode holds a real instruction
RD1_D  input  XLEN  register-file read data 1
RD2_D  input  XLEN  register-file read data 2
Rs1_D  input  REG_AW  source address 1
Rs2_D  input  REG_AW  source address 2
Rd_D  input  REG_AW  destination address
ImmExt_D  input  XLEN  sign-extended immediate
PC_D  input  XLEN  instruction PC
PCPlus4_D  input  XLEN  PC+4
RegWrite_D  input  1  control
ResultSrc_D  input  2  control
MemWrite_D  input  1  control
Jump_D  input  1  control
Branch_D  input  1  control
ALUSrc_D  input  1  control
ALUControl_D  input  ALUCTRL_W  control
Valid_E, RD1_E, RD2_E, Rs1_E, Rs2_E, Rd_E, ImmExt_E, PC_E, PCPlus4_E, RegWrite_E, ResultSrc_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E, ALUControl_E  output  same widths as _D counterparts  registered Execute copies

Behaviour:
- Fully registered, 1-cycle latency; no combinational path from input to output.
- Reset (rst_n low, asynchronous): every output 0, including Valid_E=0. Release is synchronised upstream; the first edge after release behaves as a normal load.
- Per rising edge, priority Flush_E > Stall_E > load:
  - Flush_E=1: bubble. Valid_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E := 0; ResultSrc_E, ALUSrc_E, ALUControl_E := 0; Rs1_E, Rs2_E, Rd_E := 0 so the hazard unit sees x0 and never forwards to or from the bubble. Data fields (RD1/RD2/Imm/PC/PCPlus4) := 0.
  - Stall_E=1, Flush_E=0: all outputs hold.
  - Otherwise: all _E outputs := _D inputs.
- Qualification: Valid_D=0 with load is equivalent to flush; all control and address fields are cleared.
- Simultaneous Flush_E and Stall_E: flush wins, producing a bubble.
- Reset asserted mid-stall or mid-flush: outputs go to 0 immediately, regardless of other inputs.

Optional Feature:
Macro BUBBLE_CNT_EN.
- Defined: adds output BubbleCount_E [31:0]. It increments on each edge where the register loads or flushes and the new Valid_E is 0. It does not count during stall. It saturates at 0xFFFFFFFF and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package core_pkg: XLEN, REG_AW, ALUCTRL_W constants; ResultSrc encodings (RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10); a packed struct ctrl_de_t bundling the seven control fields, with a constant CTRL_NOP of all zeros.
- One sub-module is natural: pipe_field_reg, a parameterised-width register with async active-low clear, synchronous clear (flush) and enable (~stall). It is instantiated for the data, address and control groups.
- The optional bubble counter stays inline.

Test Plan:
- Reset: drive inputs nonzero, rst_n=0 between edges -> all outputs 0 immediately. Release, load RD1_D=0x1234_5678, Rd_D=5 -> next edge RD1_E=0x12345678, Rd_E=5, Valid_E=1.
- Load: RegWrite_D=1, ALUControl_D=3'b010, ImmExt_D=0xFFFF_FFF0, PC_D=0x100 -> one edge later ALUControl_E=3'b010, ImmExt_E=0xFFFFFFF0, PC_E=0x100, PCPlus4_E=0x104.
- Flush: valid entry Rd_D=7, RegWrite_D=1, Flush_E=1 -> Valid_E=0, RegWrite_E=0, Rd_E=0, Rs1_E=0.
- Stall: load Rd=3. Then Stall_E=1 for 3 cycles with Rd_D=9 -> Rd_E stays 3. Release -> Rd_E=9 next edge.
- Flush+Stall: both high with Valid_E=1 -> bubble (Valid_E=0). Valid_D=0 with normal load -> MemWrite_E=0, Valid_E=0.
- BUBBLE_CNT_EN defined: 2 flushes, 1 stall cycle, 1 Valid_D=0 load -> BubbleCount_E=3.
